// File: rtl/gb_clk_sequencer_if.sv
// Command port of the GameBoy clock sequencer: valid/ready handshake carrying op, argument
// and stop alignment.
interface gb_clk_sequencer_if #(
    parameter int unsigned ARG_WIDTH = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [ARG_WIDTH-1:0] cmd_arg;
    logic [1:0]           cmd_align;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_align,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_align,
        output cmd_ready
    );
endinterface

// File: rtl/gb_clk_sequencer.sv
// Sequences the DMG X1 clock (stop / free-run / step N / run-until-address) and counts ticks.
// Define GBCLK_MATCH_WR_EN to let the run-until match fire on write strobes as well as reads.
module gb_clk_sequencer #(
    parameter int unsigned DIV_WIDTH = 4,
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned ARG_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 n_reset,
    gb_clk_sequencer_if.slave    cmd,
    input  logic                 clr,
    input  logic [14:0]          adr,
    input  logic                 nrd,
    input  logic                 nwr,
    input  logic                 ncs,
    output logic                 clkout,
    output logic                 running,
    output logic [CNT_WIDTH-1:0] ticks,
    output logic                 match_valid,
    output logic [CNT_WIDTH-1:0] match_at,
    output logic                 done
);

    typedef enum logic [2:0] {StIdle, StRun, StStep, StUntil, StHalt} state_e;

    localparam logic [1:0] OpStop  = 2'd0;
    localparam logic [1:0] OpRun   = 2'd1;
    localparam logic [1:0] OpStep  = 2'd2;
    localparam logic [1:0] OpUntil = 2'd3;

    state_e                 state_q;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [CNT_WIDTH-1:0]   ticks_q;
    logic [ARG_WIDTH-1:0]   remaining_q;
    logic [1:0]             align_q;
    logic [14:0]            until_adr_q;
    logic                   until_cs_q;
    logic                   armed_q;
    logic                   match_valid_q;
    logic [CNT_WIDTH-1:0]   match_at_q;
    logic                   done_q;

    logic tick, div_max, accept, strobe, match;

    always_comb begin
        div_d   = (state_q == StIdle) ? div_q : div_q + DIV_WIDTH'(1);
        // clkout is div_q's MSB, so a rising MSB on the next edge is a delivered tick.
        tick    = div_d[DIV_WIDTH-1] & ~div_q[DIV_WIDTH-1];
        div_max = &div_q;
    end

    assign cmd.cmd_ready = (state_q == StIdle) || (cmd.cmd_op == OpStop);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

`ifdef GBCLK_MATCH_WR_EN
    assign strobe = !nrd || !nwr;
`else
    assign strobe = !nrd;
    logic unused_nwr;
    assign unused_nwr = nwr;
`endif

    assign match = armed_q && (state_q == StUntil) && strobe && (adr == until_adr_q)
                   && (!until_cs_q || !ncs);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= StIdle;
            div_q         <= '0;
            ticks_q       <= '0;
            remaining_q   <= '0;
            align_q       <= '0;
            until_adr_q   <= '0;
            until_cs_q    <= 1'b0;
            armed_q       <= 1'b0;
            match_valid_q <= 1'b0;
            match_at_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div_q  <= div_d;
            if (tick) ticks_q <= ticks_q + CNT_WIDTH'(1);
            if (accept) align_q <= cmd.cmd_align;

            unique case (state_q)
                StIdle: begin
                    // clr lands first so an accepted command in the same cycle overrides it.
                    if (clr) begin
                        div_q         <= '0;
                        ticks_q       <= '0;
                        armed_q       <= 1'b0;
                        match_valid_q <= 1'b0;
                        match_at_q    <= '0;
                    end
                    if (accept) begin
                        unique case (cmd.cmd_op)
                            OpStop: done_q <= 1'b1;
                            OpRun:  state_q <= StRun;
                            OpStep: begin
                                if (cmd.cmd_arg == '0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    remaining_q <= cmd.cmd_arg;
                                    state_q     <= StStep;
                                end
                            end
                            OpUntil: begin
                                armed_q       <= 1'b1;
                                match_valid_q <= 1'b0;
                                until_adr_q   <= cmd.cmd_arg[14:0];
                                until_cs_q    <= cmd.cmd_arg[15];
                                state_q       <= StUntil;
                            end
                        endcase
                    end
                end
                StRun: begin
                    if (accept) state_q <= StHalt;
                end
                StStep: begin
                    if (accept) begin
                        state_q <= StHalt;
                    end else if (remaining_q == '0) begin
                        // Leave only once the divider wraps so the last high phase is full.
                        if (div_max) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end else if (tick) begin
                        remaining_q <= remaining_q - ARG_WIDTH'(1);
                    end
                end
                StUntil: begin
                    if (match) begin
                        match_valid_q <= 1'b1;
                        match_at_q    <= ticks_q;
                        armed_q       <= 1'b0;
                        state_q       <= StHalt;
                    end
                    if (accept) begin
                        armed_q <= 1'b0;
                        state_q <= StHalt;
                    end
                end
                StHalt: begin
                    if (div_max && (ticks_q[1:0] == align_q)) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign clkout      = div_q[DIV_WIDTH-1];
    assign running     = (state_q != StIdle);
    assign ticks       = ticks_q;
    assign match_valid = match_valid_q;
    assign match_at    = match_at_q;
    assign done        = done_q;

endmodule

// File: doc/gb_clk_sequencer.md
Name: gb_clk_sequencer

Overview:
- Sequences the external clock fed to the DMG X1 pin (pin 74) and counts the ticks delivered.
- Accepts commands over a valid/ready port: stop, free-run, step N ticks, run until a bus access to a given address.
- Timestamps the first matching bus access in ticks.
- Sits between the board button/switch logic and the SB_IO-registered GameBoy bus inputs; replaces ad-hoc clock gating in the top level.

Parameters:
- DIV_WIDTH, 4: divider width; clkout = divider MSB; clkout period = 2^DIV_WIDTH clk.
- CNT_WIDTH, 32: width of tick counter and match timestamp.
- ARG_WIDTH, 16: width of cmd_arg.

Ports:
- clk  in  1  system clock (PLL output).
- n_reset  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid && ready.
- cmd_op  in  2  0=STOP, 1=RUN, 2=STEP, 3=UNTIL.
- cmd_arg  in  ARG_WIDTH  STEP: tick count; UNTIL: address [14:0], bit 15 = require ncs low.
- cmd_align  in  2  stop alignment: halt only when ticks[1:0]==cmd_align.
- clr  in  1  synchronous clear of ticks, match state and divider; only honoured in IDLE.
- adr  in  15  registered GameBoy address.
- nrd, nwr, ncs  in  1  registered bus strobes, active low.
- clkout  out  1  clock to GameBoy.
- running  out  1  state != IDLE.
- ticks  out  CNT_WIDTH  clkout rising edges delivered since last clr.
- match_valid  out  1  sticky; a match was captured.
- match_at  out  CNT_WIDTH  value of ticks at the match.
- done  out  1  one-cycle pulse on entry to IDLE from any other state.

Behaviour:
- Reset (async, n_reset low) sets every output to 0, state=IDLE, divider=0, armed=0. Reset mid-run stops clkout immediately (low).
- States: IDLE, RUN, STEP, UNTIL, HALT.
- Divider increments each clk in RUN/STEP/UNTIL/HALT and is frozen in IDLE.
- clkout is the registered divider MSB.
- tick = cycle where the next divider MSB is 1 and the current clkout is 0. ticks increments on that cycle (wraps at 2^CNT_WIDTH).
- cmd_ready=1 in IDLE. In other states it is 1 only for cmd_op=STOP, which is the only command taken while busy.
- IDLE: RUN→RUN; STEP with arg=0→done pulse, stay IDLE; STEP with arg>0→STEP (remaining=arg); UNTIL→UNTIL (armed=1, match_valid cleared); STOP→done pulse.
- RUN: STOP→HALT.
- STEP: decrement remaining per tick. When remaining reaches 0, go to IDLE once the divider wraps to 0 (clkout low). cmd_align is ignored in STEP.
- UNTIL: on any cycle with armed && !nrd && adr==arg[14:0] && (!arg[15] || !ncs), set match_valid=1, match_at=ticks, armed=0, go to HALT. STOP also→HALT.
- HALT: keep clocking until the cycle where divider==all-ones and ticks[1:0]==align latched at command acceptance; then next state is IDLE with divider=0 and clkout=0. Worst case 4 ticks.
- A match and a tick in the same cycle: match_at takes the pre-increment ticks.
- A match while a STOP is accepted in the same cycle: the match is recorded, then HALT.
- clr outside IDLE is ignored. A clr in the same cycle as an accepted command: clr is applied first, then the command.
- clkout never produces a high phase shorter than 2^(DIV_WIDTH-1) clk.

Optional Feature:
- GBCLK_MATCH_WR_EN defined: the UNTIL match also fires on !nwr (read or write strobe).
- Undefined: nwr is ignored (port remains, unused); only reads match.

Test Plan:
- Reset, clr, STEP arg=5 (DIV_WIDTH=4) → exactly 5 clkout rising edges 16 clk apart; ticks=5; done pulses once; clkout low at IDLE; 80±8 clk total.
- RUN, then STOP with align=2 issued at ticks=9 → halts with ticks=10, clkout low, done pulse; further cycles keep ticks at 10.
- UNTIL arg=0x8100; drive nrd=0, ncs=0, adr=0x100 on the cycle with ticks=1234 → match_valid=1, match_at=1234, HALT, then IDLE at ticks=1236 with align=0.
- UNTIL arg=0x0100 with ncs=1, nwr=0, nrd=1 at adr 0x100 → no match without macro; match with GBCLK_MATCH_WR_EN.
- n_reset asserted while clkout high in RUN → clkout=0, ticks=0, running=0 immediately, no done pulse; STEP arg=0 → done only, ticks unchanged.
- clr during RUN → ignored, ticks keep counting; clr in IDLE with ticks=0xFFFFFFFF → ticks=0, match_valid=0; RUN from ticks=0xFFFFFFFF without clr → wraps to 0.
